// File: rtl/sram_rr_arbiter_if.sv
// Bus bundle between two SRAM clients, the round-robin arbiter and the SRAM controller.
// The slave modport is the arbiter's view; master is the clients-plus-controller side.
interface sram_rr_arbiter_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic          err0;
  logic          err1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_ready,
    output ack0, ack1, err0, err1, rdata0, rdata1, mem_rd, mem_wr, mem_addr, mem_wdata, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_ready,
    input  ack0, ack1, err0, err1, rdata0, rdata1, mem_rd, mem_wr, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/sram_rr_arbiter.sv
// Two-port round-robin arbiter in front of a single SRAM controller, with a
// watchdog that completes a transaction with an error when ready never arrives.
module sram_rr_arbiter #(
  parameter int unsigned AW      = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  sram_rr_arbiter_if.slave  bus
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_grant_q, last_grant_d;
  logic          we_q, we_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          err0_q, err0_d;
  logic          err1_q, err1_d;
  logic          mem_rd_q, mem_rd_d;
  logic          mem_wr_q, mem_wr_d;
  logic          busy_q;
  logic          sel_c;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state plus the next value of every registered output
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    // Port 1 wins when alone, or on a tie when port 0 was served last
    sel_c        = bus.req1 & (~bus.req0 | ~last_grant_q);

    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant_d  = sel_c;
          we_d     = sel_c ? bus.we1    : bus.we0;
          addr_d   = sel_c ? bus.addr1  : bus.addr0;
          wdata_d  = sel_c ? bus.wdata1 : bus.wdata0;
          mem_wr_d = we_d;
          mem_rd_d = ~we_d;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // Ready beats the watchdog when both land in the same cycle
        if (bus.mem_ready || (cnt_q == CNT_LAST)) begin
          if (!we_q) begin
            if (grant_q) rdata1_d = bus.mem_ready ? bus.mem_rdata : '0;
            else         rdata0_d = bus.mem_ready ? bus.mem_rdata : '0;
          end
          ack0_d  = ~grant_q;
          ack1_d  = grant_q;
          err0_d  = ~grant_q & ~bus.mem_ready;
          err1_d  = grant_q & ~bus.mem_ready;
          state_d = RESP;
        end
      end
      RESP: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      busy_q       <= (state_d != IDLE);
    end
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.err0      = err0_q;
  assign bus.err1      = err1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench for sram_rr_arbiter: table of single-port transactions against an SRAM
// stub with programmable ready latency, plus reset, stray-ready and tie sequences.
module tb_sram_rr_arbiter;

  typedef struct {
    logic       port;
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    int         lat;        // stub ready latency, 0 = never ready
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  typedef struct {
    vec_t v;
    int   exp_lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  sram_rr_arbiter_if #(.AW(4), .DW(8)) bus ();

  sram_rr_arbiter #(.AW(4), .DW(8), .TIMEOUT(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   strobe_cyc = 0;
  int   strobe_cnt = 0;
  exp_t sb[$];

  logic [7:0] stub_mem [16];
  logic [7:0] stub_data = 8'h00;
  int         stub_lat = 1;
  int         pcnt = 0;
  bit         pend = 1'b0;
  bit         stray = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event not allowed here", name);
  endfunction

  // SRAM controller stub: ready pulse stub_lat negedges after the strobe
  always @(negedge clk) begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 8'hEE;
    if (stray) begin
      bus.mem_ready = 1'b1;
      stray = 1'b0;
    end
    if (pend) begin
      pcnt++;
      if (pcnt == stub_lat) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = stub_data;
        pend = 1'b0;
      end
    end
    if (reset_n && (bus.mem_rd || bus.mem_wr)) begin
      if (bus.mem_wr) stub_mem[bus.mem_addr] = bus.mem_wdata;
      stub_data = stub_mem[bus.mem_addr];
      pend = (stub_lat != 0);
      pcnt = 0;
    end
  end

  // Monitor: strobes checked against the head of the scoreboard, acks pop it
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (reset_n) begin
      if (bus.mem_rd && bus.mem_wr) fail("strobe_both");
      if (bus.mem_rd || bus.mem_wr) begin
        strobe_cnt++;
        strobe_cyc = cyc;
        if (sb.size() == 0) fail("unexpected_strobe");
        else begin
          chk("strobe_kind", 32'(bus.mem_wr), 32'(sb[0].v.we));
          chk("mem_addr", 32'(bus.mem_addr), 32'(sb[0].v.addr));
          if (sb[0].v.we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(sb[0].v.wdata));
        end
      end
      if (bus.ack0 || bus.ack1) begin
        if (sb.size() == 0) fail("unexpected_ack");
        else begin
          e = sb.pop_front();
          chk("ack_port", 32'(bus.ack1), 32'(e.v.port));
          chk("ack_single", 32'(bus.ack0 & bus.ack1), 32'd0);
          chk("rdata", 32'(e.v.port ? bus.rdata1 : bus.rdata0), 32'(e.v.exp_rdata));
          chk("err", 32'(e.v.port ? bus.err1 : bus.err0), 32'(e.v.exp_err));
          chk("latency", 32'(cyc - strobe_cyc), 32'(e.exp_lat));
          chk("strobe_count", 32'(strobe_cnt), 32'd1);
          chk("busy_resp", 32'(bus.busy), 32'd1);
          strobe_cnt = 0;
        end
      end
      if ((bus.err0 && !bus.ack0) || (bus.err1 && !bus.ack1)) fail("err_without_ack");
    end
  end

  task automatic push(input vec_t v);
    exp_t e;
    e.v = v;
    e.exp_lat = (v.lat == 0 || v.lat > 8) ? 9 : v.lat + 1;
    sb.push_back(e);
  endtask

  task automatic drive_port(input vec_t v);
    if (!v.port) begin
      bus.req0 = 1'b1; bus.we0 = v.we; bus.addr0 = v.addr; bus.wdata0 = v.wdata;
    end else begin
      bus.req1 = 1'b1; bus.we1 = v.we; bus.addr1 = v.addr; bus.wdata1 = v.wdata;
    end
  endtask

  task automatic run_single(input vec_t v);
    bit got = 1'b0;
    stub_lat = v.lat;
    push(v);
    @(negedge clk);
    drive_port(v);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (v.port ? bus.ack1 : bus.ack0) got = 1'b1;
    end
    if (!got) fail("ack_wait");
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset_n = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    #1;
    chk({tag, "_ack0"}, 32'(bus.ack0), 32'd0);
    chk({tag, "_ack1"}, 32'(bus.ack1), 32'd0);
    chk({tag, "_err0"}, 32'(bus.err0), 32'd0);
    chk({tag, "_err1"}, 32'(bus.err1), 32'd0);
    chk({tag, "_rdata0"}, 32'(bus.rdata0), 32'd0);
    chk({tag, "_rdata1"}, 32'(bus.rdata1), 32'd0);
    chk({tag, "_mem_rd"}, 32'(bus.mem_rd), 32'd0);
    chk({tag, "_mem_wr"}, 32'(bus.mem_wr), 32'd0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    sb.delete();
    strobe_cnt = 0;
    pend = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    vec_t tbl [11];
    vec_t p0q [3];
    vec_t p1q [3];
    vec_t v;
    bit   seen;
    int   i0, i1;

    for (int i = 0; i < 16; i++) stub_mem[i] = 8'h00;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;

    //        port  we    addr   wdata  lat  rdata  err
    tbl[0]  = '{1'b0, 1'b1, 4'h3, 8'hA5, 2, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 4'h3, 8'h00, 3, 8'hA5, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 4'h3, 8'h00, 1, 8'hA5, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 4'h7, 8'h5C, 4, 8'hA5, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 4'h7, 8'h00, 8, 8'h5C, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 4'h7, 8'h00, 0, 8'h00, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 4'hF, 8'h3C, 0, 8'h00, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 4'h3, 8'hFF, 0, 8'h5C, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 4'hF, 8'h00, 5, 8'h3C, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 4'h0, 8'h00, 6, 8'h00, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 4'h3, 8'h00, 7, 8'hFF, 1'b0};

    do_reset("reset0");
    for (int i = 0; i < 11; i++) run_single(tbl[i]);

    // Stray ready while idle must not produce an ack
    stray = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("stray_no_ack", 32'(bus.ack0 | bus.ack1), 32'd0);
      chk("stray_idle", 32'(bus.busy), 32'd0);
    end

    // Reset in the middle of WAIT abandons the transaction
    stub_lat = 0;
    v = '{1'b1, 1'b0, 4'h7, 8'h00, 0, 8'h00, 1'b1};
    push(v);
    @(negedge clk);
    drive_port(v);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_rd) seen = 1'b1;
    end
    if (!seen) fail("midwait_strobe_wait");
    repeat (2) @(negedge clk);
    do_reset("reset_wait");
    repeat (12) begin
      @(negedge clk);
      chk("post_reset_no_ack", 32'(bus.ack0 | bus.ack1), 32'd0);
      chk("post_reset_idle", 32'(bus.busy), 32'd0);
    end
    run_single('{1'b0, 1'b0, 4'h3, 8'h00, 2, 8'hFF, 1'b0});

    // Both ports requesting continuously: grants alternate starting with port 0
    do_reset("reset_pair");
    stub_lat = 2;
    p0q[0] = '{1'b0, 1'b1, 4'h1, 8'h11, 2, 8'h00, 1'b0};
    p1q[0] = '{1'b1, 1'b1, 4'h2, 8'h22, 2, 8'h00, 1'b0};
    p0q[1] = '{1'b0, 1'b0, 4'h2, 8'h00, 2, 8'h22, 1'b0};
    p1q[1] = '{1'b1, 1'b0, 4'h1, 8'h00, 2, 8'h11, 1'b0};
    p0q[2] = '{1'b0, 1'b1, 4'h4, 8'h44, 2, 8'h22, 1'b0};
    p1q[2] = '{1'b1, 1'b1, 4'h5, 8'h55, 2, 8'h11, 1'b0};
    for (int i = 0; i < 3; i++) begin
      push(p0q[i]);
      push(p1q[i]);
    end
    @(negedge clk);
    drive_port(p0q[0]);
    drive_port(p1q[0]);
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 200 && (i0 < 3 || i1 < 3); c++) begin
      @(negedge clk);
      if (bus.ack0) begin
        i0++;
        if (i0 < 3) drive_port(p0q[i0]);
        else        bus.req0 = 1'b0;
      end
      if (bus.ack1) begin
        i1++;
        if (i1 < 3) drive_port(p1q[i1]);
        else        bus.req1 = 1'b0;
      end
    end
    if (i0 < 3 || i1 < 3) fail("pair_ack_wait");
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
